// File: rtl/arrow_key_judge_ctrl.sv
// Judges the first new arrow-key press from a PS/2 set-2 byte stream against the
// expected lane within a fixed cycle window, and keeps saturating hit/miss scores.
module arrow_key_judge_ctrl #(
   parameter int WINDOW_CYCLES = 25000000,
   parameter int CNT_W         = 25,
   parameter int SCORE_W       = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [2:0]         line_6,
   input  logic [7:0]         received_data,
   input  logic               received_data_en,
   output logic               busy,
   output logic               done,
   output logic               correct,
   output logic               incorrect,
   output logic               timeout,
   output logic               up,
   output logic               down,
   output logic               left,
   output logic               right,
   output logic [SCORE_W-1:0] hits,
   output logic [SCORE_W-1:0] misses
);

   typedef enum logic {IDLE, ARMED} state_t;

   localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(WINDOW_CYCLES - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   state_t             stateQ, stateD;
   logic [CNT_W-1:0]   cntQ, cntD;
   logic [2:0]         expQ, expD;
   logic               extQ, extD, brkQ, brkD;
   logic [3:0]         heldQ, heldD;
   logic               doneQ, doneD;
   logic               correctQ, correctD;
   logic               incorrectQ, incorrectD;
   logic               timeoutQ, timeoutD;
   logic [SCORE_W-1:0] hitsQ, hitsD, missesQ, missesD;

   logic       codeByte, newPress, expNone, finish, timedOut, judgedHit;
   logic [3:0] arrowHit;
   logic [2:0] pressLane;

   // Byte classification; held bits are ordered {right, left, down, up}
   always_comb begin
      arrowHit  = 4'b0000;
      pressLane = 3'd0;
      codeByte  = received_data_en && (received_data != 8'hE0) && (received_data != 8'hF0);
      case (received_data)
         8'h75:   begin arrowHit = 4'b0001; pressLane = 3'd1; end
         8'h72:   begin arrowHit = 4'b0010; pressLane = 3'd2; end
         8'h6B:   begin arrowHit = 4'b0100; pressLane = 3'd3; end
         8'h74:   begin arrowHit = 4'b1000; pressLane = 3'd4; end
         default: begin arrowHit = 4'b0000; pressLane = 3'd0; end
      endcase
      newPress = codeByte && !brkQ && (arrowHit != 4'b0000) && ((heldQ & arrowHit) == 4'b0000);
      expNone  = (expQ == 3'd0) || (expQ > 3'd4);
   end

   always_comb begin
      extD  = extQ;
      brkD  = brkQ;
      heldD = heldQ;
      if (received_data_en) begin
         if (received_data == 8'hE0) begin
            extD = 1'b1;
         end else if (received_data == 8'hF0) begin
            brkD = 1'b1;
         end else begin
            extD = 1'b0;
            brkD = 1'b0;
            if (brkQ) heldD = heldQ & ~arrowHit;
            else      heldD = heldQ | arrowHit;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stateQ     <= IDLE;
         cntQ       <= '0;
         expQ       <= 3'd0;
         extQ       <= 1'b0;
         brkQ       <= 1'b0;
         heldQ      <= 4'b0000;
         doneQ      <= 1'b0;
         correctQ   <= 1'b0;
         incorrectQ <= 1'b0;
         timeoutQ   <= 1'b0;
         hitsQ      <= '0;
         missesQ    <= '0;
      end else begin
         stateQ     <= stateD;
         cntQ       <= cntD;
         expQ       <= expD;
         extQ       <= extD;
         brkQ       <= brkD;
         heldQ      <= heldD;
         doneQ      <= doneD;
         correctQ   <= correctD;
         incorrectQ <= incorrectD;
         timeoutQ   <= timeoutD;
         hitsQ      <= hitsD;
         missesQ    <= missesD;
      end
   end

   // A press in the final window cycle takes priority over the timeout
   always_comb begin
      stateD   = stateQ;
      cntD     = cntQ;
      expD     = expQ;
      finish   = 1'b0;
      timedOut = 1'b0;
      case (stateQ)
         IDLE: begin
            if (start) begin
               stateD = ARMED;
               cntD   = CNT_LOAD;
               expD   = line_6;
            end
         end
         ARMED: begin
            if (newPress) begin
               finish = 1'b1;
               stateD = IDLE;
            end else if (cntQ == '0) begin
               finish   = 1'b1;
               timedOut = 1'b1;
               stateD   = IDLE;
            end else begin
               cntD = cntQ - CNT_W'(1);
            end
         end
         default: stateD = IDLE;
      endcase
   end

   always_comb begin
      doneD      = finish;
      correctD   = correctQ;
      incorrectD = incorrectQ;
      timeoutD   = timeoutQ;
      hitsD      = hitsQ;
      missesD    = missesQ;
      judgedHit  = timedOut ? expNone : (!expNone && (pressLane == expQ));
      if ((stateQ == IDLE) && start) begin
         correctD   = 1'b0;
         incorrectD = 1'b0;
         timeoutD   = 1'b0;
      end
      if (finish) begin
         correctD   = judgedHit;
         incorrectD = !judgedHit;
         timeoutD   = timedOut;
         if (judgedHit) begin
            if (hitsQ != SCORE_MAX) hitsD = hitsQ + SCORE_W'(1);
         end else begin
            if (missesQ != SCORE_MAX) missesD = missesQ + SCORE_W'(1);
         end
      end
   end

   assign busy      = (stateQ == ARMED);
   assign done      = doneQ;
   assign correct   = correctQ;
   assign incorrect = incorrectQ;
   assign timeout   = timeoutQ;
   assign up        = heldQ[0];
   assign down      = heldQ[1];
   assign left      = heldQ[2];
   assign right     = heldQ[3];
   assign hits      = hitsQ;
   assign misses    = missesQ;

endmodule

// File: tb/tb_arrow_key_judge_ctrl.sv
// Randomised and directed bench for arrow_key_judge_ctrl, checked against a
// cycle-counting reference model of the judgement rules.
module tb_arrow_key_judge_ctrl;

   localparam int W    = 16;
   localparam int SMAX = 255;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [2:0] line_6 = 3'd0;
   logic [7:0] received_data = 8'h00;
   logic       received_data_en = 1'b0;
   logic       busy, done, correct, incorrect, timeout, up, down, left, right;
   logic [7:0] hits, misses;

   arrow_key_judge_ctrl #(.WINDOW_CYCLES(W), .CNT_W(5), .SCORE_W(8)) dut (
      .clock(clock), .reset(reset), .start(start), .line_6(line_6),
      .received_data(received_data), .received_data_en(received_data_en),
      .busy(busy), .done(done), .correct(correct), .incorrect(incorrect),
      .timeout(timeout), .up(up), .down(down), .left(left), .right(right),
      .hits(hits), .misses(misses)
   );

   always #5 clock = ~clock;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state: keys held per lane index 0..3 (up, down, left, right)
   bit mHeld[4];
   bit mBrk, mArmed, mDone, mCorrect, mIncorrect, mTimeout;
   int mDeadline, mExp, mHits, mMisses, cycleNum;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0h expected %0h at cycle %0d", tag, observed, expected, cycleNum);
      end
   endtask

   function automatic int laneOf(input logic [7:0] b);
      case (b)
         8'h75:   return 0;
         8'h72:   return 1;
         8'h6B:   return 2;
         8'h74:   return 3;
         default: return -1;
      endcase
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 4; i++) mHeld[i] = 0;
      mBrk = 0; mArmed = 0; mDone = 0; mCorrect = 0; mIncorrect = 0; mTimeout = 0;
      mDeadline = 0; mExp = 0; mHits = 0; mMisses = 0;
   endtask

   task automatic modelComplete(input bit hit, input bit to);
      mArmed = 0;
      mDone = 1;
      mCorrect = hit;
      mIncorrect = !hit;
      mTimeout = to;
      if (hit) mHits = (mHits < SMAX) ? mHits + 1 : SMAX;
      else     mMisses = (mMisses < SMAX) ? mMisses + 1 : SMAX;
   endtask

   task automatic modelStep(input bit st, input int ln, input bit en, input logic [7:0] d);
      bit isCode, press, expValid;
      int idx;
      cycleNum++;
      mDone = 0;
      isCode = en && d != 8'hE0 && d != 8'hF0;
      idx = isCode ? laneOf(d) : -1;
      press = (idx >= 0) && !mBrk && !mHeld[idx];
      expValid = (mExp >= 1) && (mExp <= 4);
      if (mArmed) begin
         if (press) modelComplete(expValid && (mExp - 1 == idx), 0);
         else if (cycleNum == mDeadline) modelComplete(!expValid, 1);
      end else if (st) begin
         mArmed = 1;
         mDeadline = cycleNum + W;
         mExp = ln;
         mCorrect = 0; mIncorrect = 0; mTimeout = 0;
      end
      if (en) begin
         if (d == 8'hF0) mBrk = 1;
         else if (d != 8'hE0) begin
            if (idx >= 0) mHeld[idx] = !mBrk;
            mBrk = 0;
         end
      end
   endtask

   task automatic compareAll();
      checkOutput("busy", busy, mArmed);
      checkOutput("done", done, mDone);
      checkOutput("correct", correct, mCorrect);
      checkOutput("incorrect", incorrect, mIncorrect);
      checkOutput("timeout", timeout, mTimeout);
      checkOutput("up", up, mHeld[0]);
      checkOutput("down", down, mHeld[1]);
      checkOutput("left", left, mHeld[2]);
      checkOutput("right", right, mHeld[3]);
      checkOutput("hits", hits, mHits);
      checkOutput("misses", misses, mMisses);
   endtask

   // One clock: drive inputs, clock the DUT and the model, compare 1 time unit later
   task automatic applyStimulus(input bit st, input int ln, input bit en, input logic [7:0] d);
      start = st;
      line_6 = 3'(ln);
      received_data_en = en;
      received_data = en ? d : 8'($urandom);
      @(posedge clock);
      modelStep(st, ln, en, d);
      #1;
      compareAll();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 8'h00);
   endtask

   task automatic sendByte(input logic [7:0] d);
      applyStimulus(0, 0, 1, d);
   endtask

   task automatic asyncReset();
      reset = 1'b1;
      #2;
      modelReset();
      compareAll();
      reset = 1'b0;
   endtask

   logic [7:0] byteTable [8] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1C, 8'h5A};

   initial begin
      int n;
      cycleNum = 0;
      modelReset();
      #2;
      compareAll();
      reset = 1'b0;

      // Correct up press
      applyStimulus(1, 1, 0, 8'h00);
      sendByte(8'hE0);
      sendByte(8'h75);
      checkOutput("tp1_done", done, 1);
      checkOutput("tp1_correct", correct, 1);
      checkOutput("tp1_hits", hits, 1);

      // Wrong lane, then a break that must not complete anything
      applyStimulus(1, 2, 0, 8'h00);
      sendByte(8'hE0);
      sendByte(8'h6B);
      checkOutput("tp2_incorrect", incorrect, 1);
      checkOutput("tp2_left", left, 1);
      sendByte(8'hE0);
      sendByte(8'hF0);
      sendByte(8'h6B);
      checkOutput("tp2_left_rel", left, 0);

      // Typematic repeat of held up never judges; window times out
      applyStimulus(1, 1, 0, 8'h00);
      sendByte(8'hE0);
      sendByte(8'h75);
      checkOutput("tp3_repeat_busy", busy, 1);
      idle(W);
      checkOutput("tp3_timeout", timeout, 1);
      checkOutput("tp3_incorrect", incorrect, 1);

      // Empty lane, no keys: done exactly W cycles after start
      applyStimulus(1, 0, 0, 8'h00);
      n = 0;
      do begin
         idle(1);
         n++;
      end while (!done && n < 40);
      checkOutput("tp4_latency", n, W);
      checkOutput("tp4_correct", correct, 1);
      checkOutput("tp4_timeout", timeout, 1);

      // Press on the final window cycle wins over timeout
      applyStimulus(1, 3, 0, 8'h00);
      idle(W - 1);
      sendByte(8'h6B);
      checkOutput("tp5_edge_correct", correct, 1);
      checkOutput("tp5_edge_timeout", timeout, 0);
      sendByte(8'hF0);
      sendByte(8'h6B);

      // Start while armed is ignored
      applyStimulus(1, 4, 0, 8'h00);
      idle(2);
      applyStimulus(1, 1, 0, 8'h00);
      sendByte(8'h74);
      checkOutput("tp6_ignore_start", correct, 1);
      sendByte(8'hF0);
      sendByte(8'h74);

      // Start with a code byte while idle: byte tracked, not judged
      applyStimulus(1, 2, 1, 8'h72);
      checkOutput("tp7_not_judged", busy, 1);
      idle(W + 1);
      sendByte(8'hF0);
      sendByte(8'h72);
      sendByte(8'hF0);
      sendByte(8'h75);

      // Saturate hits
      for (int i = 0; i < 260; i++) begin
         applyStimulus(1, 1, 0, 8'h00);
         sendByte(8'h75);
         sendByte(8'hF0);
         sendByte(8'h75);
      end
      checkOutput("tp8_hits_sat", hits, SMAX);

      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         bit st, en;
         st = ($urandom_range(0, 19) == 0);
         en = ($urandom_range(0, 9) < 3);
         applyStimulus(st, int'($urandom_range(0, 7)), en, byteTable[$urandom_range(0, 7)]);
      end

      // Reset in the middle of a window
      idle(W + 2);
      applyStimulus(1, 1, 0, 8'h00);
      idle(3);
      asyncReset();
      checkOutput("tp9_busy", busy, 0);
      checkOutput("tp9_done", done, 0);
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
